// File: rtl/nibble_deserializer.sv
// rtl/nibble_deserializer.sv - bit-serial to 4-bit nibble deserializer with valid/ready output
// Define NIBBLE_DESER_CNT_EN to add the 8-bit handoff counter on nib_cnt_o.
module nibble_deserializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ser_bit_i,
  input  logic       ser_valid_i,
  output logic       ser_ready_o,
  input  logic       sync_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  output logic       nib_valid_o,
`ifdef NIBBLE_DESER_CNT_EN
  output logic [7:0] nib_cnt_o,
`endif
  input  logic       nib_ready_i
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t      r_state;
  logic [2:0]  r_shift;
  logic [3:0]  r_nib;
  logic        r_valid;
  logic        w_ser_ready;
  logic        w_beat;
  logic        w_handoff;
  logic [3:0]  w_load;

  // Only the completing beat can stall; bits 0..2 of the next nibble always fit.
  assign w_ser_ready = ~((r_state == S3) & r_valid & ~nib_ready_i);
  assign w_beat      = ser_valid_i & w_ser_ready;
  assign w_handoff   = r_valid & nib_ready_i;
  assign w_load      = MSB_FIRST ? {r_shift, ser_bit_i}
                                 : {ser_bit_i, r_shift[0], r_shift[1], r_shift[2]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S0;
      r_shift <= 3'b000;
      r_nib   <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      if (w_handoff) r_valid <= 1'b0;
      if (w_beat) r_shift <= {r_shift[1:0], ser_bit_i};
      if (sync_i) begin
        r_state <= w_beat ? S1 : S0;
      end else if (w_beat) begin
        case (r_state)
          S0: r_state <= S1;
          S1: r_state <= S2;
          S2: r_state <= S3;
          default: begin
            r_state <= S0;
            r_nib   <= w_load;
            r_valid <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef NIBBLE_DESER_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= 8'd0;
    end else if (w_handoff) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign nib_cnt_o = r_cnt;
`endif

  assign ser_ready_o = w_ser_ready;
  assign nib_valid_o = r_valid;
  assign a_o         = r_nib[3];
  assign b_o         = r_nib[2];
  assign c_o         = r_nib[1];
  assign d_o         = r_nib[0];

endmodule

// File: tb/tb_nibble_deserializer.sv
// tb/tb_nibble_deserializer.sv - self-checking bench for nibble_deserializer (both bit orders)
// Counter checks are active when NIBBLE_DESER_CNT_EN is defined.
module tb_nibble_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_bit = 1'b0;
  logic ser_valid = 1'b0;
  logic sync = 1'b0;
  logic nib_ready = 1'b0;

  logic rdy1, a1, b1, c1, d1, v1;
  logic rdy0, a0, b0, c0, d0, v0;
`ifdef NIBBLE_DESER_CNT_EN
  logic [7:0] cnt1, cnt0;
`endif

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_deserializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .ser_bit_i(ser_bit), .ser_valid_i(ser_valid),
    .ser_ready_o(rdy1), .sync_i(sync), .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
    .nib_valid_o(v1),
`ifdef NIBBLE_DESER_CNT_EN
    .nib_cnt_o(cnt1),
`endif
    .nib_ready_i(nib_ready)
  );

  nibble_deserializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .ser_bit_i(ser_bit), .ser_valid_i(ser_valid),
    .ser_ready_o(rdy0), .sync_i(sync), .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0),
    .nib_valid_o(v0),
`ifdef NIBBLE_DESER_CNT_EN
    .nib_cnt_o(cnt0),
`endif
    .nib_ready_i(nib_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bits in arrival order; nibble formed from them by positional weight.
  bit       pend[$];
  int       m_val1 = 0;
  int       m_val0 = 0;
  bit       m_valid = 1'b0;
  int       m_cnt = 0;

  always @(negedge clk) begin
    bit m_rdy, beat, hand;
    if (!rst_n) begin
      pend.delete();
      m_val1 = 0; m_val0 = 0; m_valid = 1'b0; m_cnt = 0;
    end
    m_rdy = !(pend.size() == 3 && m_valid && !nib_ready);
    chk("m_ready1", int'(rdy1), int'(m_rdy));
    chk("m_ready0", int'(rdy0), int'(m_rdy));
    chk("m_valid1", int'(v1), int'(m_valid));
    chk("m_valid0", int'(v0), int'(m_valid));
    chk("m_nib1", int'({a1, b1, c1, d1}), m_val1);
    chk("m_nib0", int'({a0, b0, c0, d0}), m_val0);
`ifdef NIBBLE_DESER_CNT_EN
    chk("m_cnt1", int'(cnt1), m_cnt);
    chk("m_cnt0", int'(cnt0), m_cnt);
`endif
    if (rst_n) begin
      beat = ser_valid && m_rdy;
      hand = m_valid && nib_ready;
      if (hand) begin
        m_valid = 1'b0;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (sync) begin
        pend.delete();
        if (beat) pend.push_back(ser_bit);
      end else if (beat) begin
        pend.push_back(ser_bit);
        if (pend.size() == 4) begin
          m_val1 = 0; m_val0 = 0;
          for (int i = 0; i < 4; i++) begin
            m_val1 += int'(pend[i]) << (3 - i);
            m_val0 += int'(pend[i]) << i;
          end
          m_valid = 1'b1;
          pend.delete();
        end
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic s, input logic r);
    ser_valid = v; ser_bit = b; sync = s; nib_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Sends n[3] first, n[0] last.
  task automatic send4(input logic [3:0] n, input logic r);
    for (int i = 3; i >= 0; i--) step(1'b1, n[i], 1'b0, r);
  endtask

  initial begin
    logic [3:0] lsb_order;
    #1;
    chk("rst_ready", int'(rdy1), 1);
    chk("rst_valid", int'(v1), 0);
    chk("rst_nib", int'({a1, b1, c1, d1}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 1: bits 1,1,0,0
    send4(4'b1100, 1'b1);
    chk("t1_nib_msb", int'({a1, b1, c1, d1}), 4'b1100);
    chk("t1_valid", int'(v1), 1);
    chk("t1_nib_lsb", int'({a0, b0, c0, d0}), 4'b0011);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid_drop", int'(v1), 0);
    chk("t1_hold", int'({a1, b1, c1, d1}), 4'b1100);

    // Test 2: stream 0..15, LSB first so dut0 shows each value in order
    for (int v = 0; v < 16; v++) begin
      lsb_order = {v[0], v[1], v[2], v[3]};
      send4(lsb_order, 1'b1);
      chk("t2_stream", int'({a0, b0, c0, d0}), v);
      chk("t2_valid", int'(v0), 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 3: stall with 0x6 pending, skid three bits of 0xA
    send4(4'b0110, 1'b0);
    chk("t3_nib6", int'({a1, b1, c1, d1}), 4'h6);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_stall_ready", int'(rdy1), 0);
    chk("t3_hold6", int'({a1, b1, c1, d1}), 4'h6);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_still6", int'({a1, b1, c1, d1}), 4'h6);
    chk("t3_still_valid", int'(v1), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_nibA", int'({a1, b1, c1, d1}), 4'hA);
    chk("t3_no_bubble", int'(v1), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drained", int'(v1), 0);

    // Test 4: sync behaviour
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send4(4'b1000, 1'b1);
    chk("t4_after_sync", int'({a1, b1, c1, d1}), 4'b1000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_sync_beat", int'({a1, b1, c1, d1}), 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4_s3_sync_noload", int'(v1), 0);
    send4({1'b0, 3'b101}, 1'b1);
    send4(4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 5: asynchronous reset mid-nibble and with a nibble pending
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mid_valid", int'(v1), 0);
    chk("t5_mid_nib", int'({a1, b1, c1, d1}), 0);
    chk("t5_mid_ready", int'(rdy1), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send4(4'b1111, 1'b0);
    chk("t5_pre_valid", int'(v1), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid_clr", int'(v1), 0);
    chk("t5_nib_clr", int'({a0, b0, c0, d0}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef NIBBLE_DESER_CNT_EN
    // Test 6: 257 handoffs wrap the counter to 1
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 257; k++) send4(k[3:0], 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_cnt_wrap", int'(cnt1), 1);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
